// File: rtl/mult_div_unit_if.sv
// Execute-stage MDU port bundle: decoder controls and operands in, busy and HI/LO out.
interface mult_div_unit_if;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, mdu_op, rs_data, rt_data, input busy, hi, lo);
   modport slave  (input start, mdu_op, rs_data, rt_data, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed from operands latched at launch and committed on the last busy cycle.
//
// state | meaning
// IDLE  | no operation in flight; accepts launches and mthi/mtlo
// RUN   | counter running down; HI/LO held, new requests ignored
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   mult_div_unit_if.slave bus
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_MTHI  = 4'd3;
   localparam logic [3:0] OP_MTLO  = 4'd4;
   localparam logic [3:0] OP_MULTU = 4'd5;
   localparam logic [3:0] OP_DIVU  = 4'd6;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        launch_ok;
   logic        launch_mult;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        div_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   assign launch_ok   = bus.start && (bus.mdu_op == OP_MULT || bus.mdu_op == OP_DIV ||
                                      bus.mdu_op == OP_MULTU || bus.mdu_op == OP_DIVU);
   assign launch_mult = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU);

   // Low 64 bits of the sign-extended product equal the two's-complement signed product.
   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Signed divide via magnitudes; 0x80000000 has magnitude 0x80000000 as unsigned, so
   // the overflow case falls out naturally. Divisor forced to 1 when zero to keep the
   // divider defined; the result is discarded in that case anyway.
   assign div_signed = (op_q == OP_DIV);
   assign a_neg      = div_signed && a_q[31];
   assign b_neg      = div_signed && b_q[31];
   assign a_mag      = a_neg ? (32'd0 - a_q) : a_q;
   assign b_mag      = (b_q == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - b_q) : b_q);
   assign q_mag      = a_mag / b_mag;
   assign r_mag      = a_mag % b_mag;
   assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
   assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (launch_ok) begin
               op_d    = bus.mdu_op;
               a_d     = bus.rs_data;
               b_d     = bus.rt_data;
               cnt_d   = launch_mult ? MULT_LOAD : DIV_LOAD;
               state_d = RUN;
            end else if (bus.mdu_op == OP_MTHI) begin
               hi_d = bus.rs_data;
            end else if (bus.mdu_op == OP_MTLO) begin
               lo_d = bus.rs_data;
            end
         end
         RUN: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = IDLE;
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  OP_DIV, OP_DIVU: begin
                     if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected HI/LO and busy
// length; a negedge monitor checks HI/LO hold during busy and the result when busy falls.
module tb_mult_div_unit;

   logic clk;
   logic reset;
   mult_div_unit_if bus ();

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] ohi;
      logic [31:0] olo;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_hi, m_lo;
   int          bcnt = 0;
   logic        prev_busy = 1'b0;
   exp_t        e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cyc);
      exp_t x;
      x.hi  = hi;
      x.lo  = lo;
      x.ohi = m_hi;
      x.olo = m_lo;
      x.cyc = cyc;
      sb.push_back(x);
      m_hi = hi;
      m_lo = lo;
   endtask

   // Caller is at a negedge; inputs are seen by the next posedge, then cleared with junk operands.
   task automatic launch(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      bus.start   = 1'b1;
      bus.mdu_op  = op;
      bus.rs_data = rs;
      bus.rt_data = rt;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.mdu_op  = 4'd0;
      bus.rs_data = 32'hA5A5_5A5A;
      bus.rt_data = 32'h5A5A_A5A5;
   endtask

   task automatic move_to(input logic [3:0] op, input logic [31:0] rs);
      bus.start   = 1'b0;
      bus.mdu_op  = op;
      bus.rs_data = rs;
      @(negedge clk);
      bus.mdu_op  = 4'd0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         sb.delete();
         bcnt      = 0;
         prev_busy = 1'b0;
      end else begin
         if (bus.busy === 1'b1) begin
            bcnt++;
            if (sb.size() > 0) begin
               chk("hold_hi", bus.hi, sb[0].ohi);
               chk("hold_lo", bus.lo, sb[0].olo);
            end
         end else if (prev_busy) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("res_hi", bus.hi, e.hi);
               chk("res_lo", bus.lo, e.lo);
               chk("busy_len", 32'(bcnt), 32'(e.cyc));
            end
            bcnt = 0;
         end
         prev_busy = bus.busy;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      bus.start   = 1'b0;
      bus.mdu_op  = 4'd0;
      bus.rs_data = 32'd0;
      bus.rt_data = 32'd0;
      m_hi        = 32'd0;
      m_lo        = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);

      // mult -2 * 3
      push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      launch(4'd1, 32'hFFFF_FFFE, 32'd3);
      wait_idle();

      // multu 0xFFFFFFFE * 3
      push(32'h0000_0002, 32'hFFFF_FFFA, 5);
      launch(4'd5, 32'hFFFF_FFFE, 32'd3);
      wait_idle();

      // div -7 / 2
      push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      launch(4'd2, 32'hFFFF_FFF9, 32'd2);
      wait_idle();

      // preset via mthi/mtlo, then divu by zero leaves them untouched
      move_to(4'd3, 32'h11);
      m_hi = 32'h11;
      chk("mthi_11", bus.hi, 32'h11);
      move_to(4'd4, 32'h22);
      m_lo = 32'h22;
      chk("mtlo_22", bus.lo, 32'h22);
      push(32'h11, 32'h22, 10);
      launch(4'd6, 32'd7, 32'd0);
      wait_idle();

      // mthi in idle with start asserted is still a plain move
      bus.start = 1'b1;
      move_to(4'd3, 32'h1234);
      bus.start = 1'b0;
      m_hi = 32'h1234;
      chk("mthi_1234", bus.hi, 32'h1234);
      chk("mthi_lo_kept", bus.lo, 32'h22);
      chk("mthi_busy", 32'(bus.busy), 32'd0);

      // div 100 / 7 with mtlo and a stray start issued mid-run
      push(32'd2, 32'd14, 10);
      launch(4'd2, 32'd100, 32'd7);
      repeat (2) @(negedge clk);
      move_to(4'd4, 32'hDEAD);
      bus.start = 1'b1;
      move_to(4'd1, 32'h0BAD);
      bus.start = 1'b0;
      wait_idle();

      // signed overflow case
      push(32'h0, 32'h8000_0000, 10);
      launch(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();

      // divu large / 16
      push(32'hF, 32'h0FFF_FFFF, 10);
      launch(4'd6, 32'hFFFF_FFFF, 32'h10);
      wait_idle();

      // div 7 / -2: remainder takes dividend sign
      push(32'd1, 32'hFFFF_FFFD, 10);
      launch(4'd2, 32'd7, 32'hFFFF_FFFE);
      wait_idle();

      // back-to-back: second start in the cycle busy falls
      push(32'd1, 32'd0, 5);
      launch(4'd5, 32'h0001_0000, 32'h0001_0000);
      wait_idle();
      push(32'h3FFF_FFFF, 32'h0000_0001, 5);
      launch(4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      wait_idle();

      // reset during a divide discards it immediately
      launch(4'd2, 32'd1000, 32'd3);
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_hi", bus.hi, 32'd0);
      chk("mid_rst_lo", bus.lo, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      push(32'd0, 32'd30, 5);
      launch(4'd1, 32'd5, 32'd6);
      wait_idle();

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
